pipelined_divider: RTL and testbench
====================================

Name: pipelined_divider

Overview:
- Fully pipelined unsigned restoring divider; the inverse operation of the team's shift-add multiplier.
- Accepts one dividend/divisor pair per clock and produces quotient and remainder a fixed latency later.
- Sits in the same arithmetic datapath as the multiplier.
- One stage per dividend bit; each stage does shift-in, trial-subtract and restore.

Parameters:
- DIVIDEND_W, 8, width of dividend and quotient (number of pipeline stages).
- DIVISOR_W, 4, width of divisor and remainder.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  operand-valid; a/b sampled on any clk edge where start=1.
- a  input  DIVIDEND_W  dividend (unsigned).
- b  input  DIVISOR_W  divisor (unsigned).
- quotient  output  DIVIDEND_W  registered quotient.
- remainder  output  DIVISOR_W  registered remainder.
- valid  output  1  one-cycle pulse marking quotient/remainder as a new result.
- div_by_zero  output  1  present only with DIV_ZERO_FLAG_EN; qualifies the same result as valid.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state updates on rising clk; reset takes priority over everything else.
- Reset values: quotient=0, remainder=0, valid=0, div_by_zero=0. Every stage valid bit is cleared. Stage data registers may also be cleared (implementer's choice; not observable).
- Acceptance: there is no ready signal and the block never stalls. A start on every cycle is legal, and each start yields exactly one valid pulse.
- Stage structure: stages 0..DIVIDEND_W-1. Each stage carries:
  - a stage-valid bit;
  - the remaining dividend bits;
  - the divisor;
  - a DIVISOR_W+1-bit partial remainder r, initialised to 0 at entry;
  - the quotient bits built so far;
  - a zero-divisor flag, set at entry when b==0.
- Stage k operation (processes dividend bit DIVIDEND_W-1-k):
  - t = {r[DIVISOR_W-1:0], dividend bit}, DIVISOR_W+1 bits.
  - If t >= {1'b0,b}: r_next = t - b and quotient bit = 1. Otherwise r_next = t and quotient bit = 0.
  - Comparison and subtract use DIVISOR_W+1-bit unsigned arithmetic; r_next always fits in DIVISOR_W bits.
- Output register: on the cycle the last stage is valid:
  - quotient <= accumulated quotient;
  - remainder <= r[DIVISOR_W-1:0];
  - valid <= 1.
  - Otherwise valid <= 0, and quotient/remainder hold their last value.
- Latency: start sampled at edge N gives valid=1 after edge N+DIVIDEND_W+1 (9 cycles at defaults). Throughput is 1 result per cycle. Results leave in acceptance order.
- Bubbles: start=0 inserts a bubble that propagates with stage-valid=0 and produces no valid pulse. Stage data under a bubble is don't-care.
- Divide by zero (b==0):
  - quotient forced to all ones and remainder forced to 0 at the output register.
  - This applies regardless of the macro; the flag travels with the operand.
- Correctness invariant: for every valid result with b!=0, a == quotient*b + remainder and remainder < b.
- Reset mid-operation:
  - All in-flight operations are discarded; no valid pulse for them ever appears.
  - valid=0 on the cycle after reset is sampled.
  - A start sampled together with reset is ignored.
  - The first start after reset is released behaves normally.
- Operands are not required to be held after the sampling edge.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined:
  - div_by_zero port exists and is registered alongside quotient.
  - It equals 1 exactly when the result being presented had b==0, and is 0 otherwise.
  - It updates only with valid=1 and holds its value otherwise.
  - Reset value 0.
- Undefined:
  - Port and flag output register are absent.
  - Zero-divisor results still produce quotient=all ones and remainder=0 with no other indication.

Test Plan:
- Single op: a=200, b=7, start pulsed one cycle → exactly 9 cycles later valid=1 for one cycle, quotient=28, remainder=4.
- Boundaries: a=255,b=1 → q=255,r=0; a=5,b=15 → q=0,r=5; a=0,b=9 → q=0,r=0; a=255,b=15 → q=17,r=0.
- Back-to-back: starts on 3 consecutive cycles with (100,3), (77,10), (15,15) → valid high 3 consecutive cycles with (33,1), (7,7), (1,0) in order.
- Bubbles: starts at cycles 0, 2, 3 → valid pulses at cycles 9, 11, 12 only; quotient holds between pulses.
- Divide by zero: a=123, b=0 → q=255, r=0. With DIV_ZERO_FLAG_EN, div_by_zero=1 for that result and 0 for a following (10,2) → (5,0).
- Reset mid-flight: 4 ops accepted, then reset high one cycle at cycle 3 → valid never pulses for them. All outputs read 0 after reset. A new op (9,2) accepted after release → (4,1) with 9-cycle latency.

Source files
------------

// File: rtl/pipelined_divider.sv
// -----------------------------------------------------------------------------
// pipelined_divider
//   Fully pipelined unsigned restoring divider, one stage per dividend bit.
//   It accepts one dividend/divisor pair per clock and never stalls. Results
//   appear DIVIDEND_W+1 cycles after the sampling edge, in acceptance order.
//   A zero divisor yields quotient = all ones and remainder = 0.
//
//   Optional feature macro: DIV_ZERO_FLAG_EN
//     When defined, adds the registered div_by_zero output, which qualifies
//     the result together with valid.
//
// Parameters
//   DIVIDEND_W  width of dividend and quotient, and the number of stages
//   DIVISOR_W   width of divisor and remainder
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        operand valid; a/b are sampled on every edge where start=1
//   a            dividend (unsigned)
//   b            divisor (unsigned)
//   quotient     registered quotient, holds between results
//   remainder    registered remainder, holds between results
//   valid        one-cycle pulse marking a new quotient/remainder
//   div_by_zero  (DIV_ZERO_FLAG_EN only) result had b == 0
// -----------------------------------------------------------------------------
module pipelined_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  valid
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                  div_by_zero
`endif
);

  // Index 0 is the operand capture register. Index k+1 holds the state
  // after stage k has processed dividend bit DIVIDEND_W-1-k.
  logic                  vld_p [0:DIVIDEND_W];
  logic                  zf_p  [0:DIVIDEND_W];
  logic [DIVIDEND_W-1:0] dvd_p [0:DIVIDEND_W-1];
  logic [DIVISOR_W-1:0]  dvs_p [0:DIVIDEND_W-1];
  logic [DIVISOR_W-1:0]  rem_p [1:DIVIDEND_W];
  logic [DIVIDEND_W-1:0] quo_p [1:DIVIDEND_W];

  // Per-stage combinational result: {quotient bit, next partial remainder}
  logic [DIVISOR_W:0]    step   [0:DIVIDEND_W-1];
  logic [DIVIDEND_W-1:0] quo_nx [1:DIVIDEND_W];

  // One restoring step. The partial remainder entering a stage is always
  // below the divisor, so the shifted trial value needs only one extra bit.
  // When the subtraction is taken the difference fits in DIVISOR_W bits,
  // so it can be formed modulo 2^DIVISOR_W from the low bits of t.
  function automatic logic [DIVISOR_W:0] trial_step(
    input logic [DIVISOR_W-1:0] r,
    input logic                 din,
    input logic [DIVISOR_W-1:0] d
  );
    logic [DIVISOR_W:0]   t;
    logic [DIVISOR_W-1:0] diff;
    t    = {r, din};
    diff = t[DIVISOR_W-1:0] - d;
    if (t >= {1'b0, d}) begin
      return {1'b1, diff};
    end
    return {1'b0, t[DIVISOR_W-1:0]};
  endfunction

  // A zero divisor overrides whatever the stages accumulated.
  function automatic logic [DIVIDEND_W+DIVISOR_W-1:0] zero_div_force(
    input logic                  zf,
    input logic [DIVIDEND_W-1:0] q,
    input logic [DIVISOR_W-1:0]  r
  );
    if (zf) begin
      return {{DIVIDEND_W{1'b1}}, {DIVISOR_W{1'b0}}};
    end
    return {q, r};
  endfunction

  // Stage datapath (combinational part of every stage)
  always_comb begin
    step[0]   = trial_step('0, dvd_p[0][DIVIDEND_W-1], dvs_p[0]);
    quo_nx[1] = '0;
    quo_nx[1][DIVIDEND_W-1] = step[0][DIVISOR_W];
    for (int k = 1; k < DIVIDEND_W; k++) begin
      step[k]     = trial_step(rem_p[k], dvd_p[k][DIVIDEND_W-1-k], dvs_p[k]);
      quo_nx[k+1] = quo_p[k];
      quo_nx[k+1][DIVIDEND_W-1-k] = step[k][DIVISOR_W];
    end
  end

  // Capture and stage registers: data path, no reset
  always_ff @(posedge clk) begin
    dvd_p[0] <= a;
    dvs_p[0] <= b;
    zf_p[0]  <= (b == '0);
    for (int k = 0; k < DIVIDEND_W-1; k++) begin
      dvd_p[k+1] <= dvd_p[k];
      dvs_p[k+1] <= dvs_p[k];
    end
    for (int k = 0; k < DIVIDEND_W; k++) begin
      zf_p[k+1]  <= zf_p[k];
      rem_p[k+1] <= step[k][DIVISOR_W-1:0];
      quo_p[k+1] <= quo_nx[k+1];
    end
  end

  // Stage valid chain and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= DIVIDEND_W; k++) begin
        vld_p[k] <= 1'b0;
      end
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      vld_p[0] <= start;
      for (int k = 0; k < DIVIDEND_W; k++) begin
        vld_p[k+1] <= vld_p[k];
      end
      valid <= vld_p[DIVIDEND_W];
      if (vld_p[DIVIDEND_W]) begin
        {quotient, remainder} <= zero_div_force(zf_p[DIVIDEND_W],
                                                quo_p[DIVIDEND_W],
                                                rem_p[DIVIDEND_W]);
`ifdef DIV_ZERO_FLAG_EN
        div_by_zero <= zf_p[DIVIDEND_W];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_divider.sv
// -----------------------------------------------------------------------------
// tb_pipelined_divider
//   Directed scoreboard bench for pipelined_divider at default parameters.
//   The driver pushes hand-computed results when it issues an operation; the
//   monitor pops and compares on every valid pulse, checks latency, output
//   hold between pulses, and output clearing after reset.
// -----------------------------------------------------------------------------
module tb_pipelined_divider;

  localparam int DW  = 8;
  localparam int VW  = 4;
  localparam int LAT = DW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          valid;
`ifdef DIV_ZERO_FLAG_EN
  logic          div_by_zero;
`endif

  pipelined_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .valid     (valid)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int            t;
  } exp_t;

  exp_t sb[$];

  int   edge_cnt   = 0;
  logic rst_q      = 1'b0;
  logic finish_req = 1'b0;
  int   n_chk      = 0;
  int   n_fail     = 0;
  logic [DW-1:0] last_q = '0;
  logic [VW-1:0] last_r = '0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_q    <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Monitor: all comparisons live here
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_quotient", {24'd0, quotient}, 32'd0);
      chk("reset_remainder", {28'd0, remainder}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
      chk("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
`endif
    end else if (valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, e.q});
        chk("remainder", {28'd0, remainder}, {28'd0, e.r});
        chk("latency", edge_cnt - e.t, LAT);
`ifdef DIV_ZERO_FLAG_EN
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
`endif
      end
    end else begin
      chk("hold_quotient", {24'd0, quotient}, {24'd0, last_q});
      chk("hold_remainder", {28'd0, remainder}, {28'd0, last_r});
    end
    last_q = quotient;
    last_r = remainder;
    if (finish_req) begin
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic issue(input int av, input int bv, input int qv, input int rv, input bit zv);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a     = av[DW-1:0];
    b     = bv[VW-1:0];
    e.q   = qv[DW-1:0];
    e.r   = rv[VW-1:0];
    e.z   = zv;
    e.t   = edge_cnt + 1;
    sb.push_back(e);
  endtask

  // Issue an operation that reset will discard: nothing is expected
  task automatic issue_lost(input int av, input int bv);
    @(negedge clk);
    start = 1'b1;
    a     = av[DW-1:0];
    b     = bv[VW-1:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      a     = $urandom_range(0, 255);
      b     = $urandom_range(0, 15);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single operation
    issue(200, 7, 28, 4, 0);
    idle(1);
    drain();

    // boundaries, back to back
    issue(255, 1, 255, 0, 0);
    issue(5, 15, 0, 5, 0);
    issue(0, 9, 0, 0, 0);
    issue(255, 15, 17, 0, 0);
    idle(1);
    drain();

    // three consecutive starts
    issue(100, 3, 33, 1, 0);
    issue(77, 10, 7, 7, 0);
    issue(15, 15, 1, 0, 0);
    idle(1);
    drain();

    // bubbles: starts at cycles 0, 2, 3
    issue(50, 6, 8, 2, 0);
    idle(1);
    issue(99, 9, 11, 0, 0);
    issue(13, 4, 3, 1, 0);
    idle(1);
    drain();

    // divide by zero followed by a normal op
    issue(123, 0, 255, 0, 1);
    issue(10, 2, 5, 0, 0);
    idle(1);
    drain();

    // reset mid-flight, with a start presented during reset
    issue_lost(60, 5);
    issue_lost(33, 3);
    issue_lost(1, 1);
    issue_lost(250, 9);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    a     = 8'd7;
    b     = 4'd7;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    idle(14);

    // first op after reset release
    issue(9, 2, 4, 1, 0);
    idle(1);
    drain();
    idle(2);
    finish_req = 1'b1;
  end

endmodule
